posit_encoder: RTL and testbench

POSIT_ENCODER -- requirements
Module: posit_encoder

---
 rtl/posit_pkg.sv | 34 +++
 rtl/posit_encoder_if.sv | 29 ++
 rtl/posit_round.sv | 23 ++
 rtl/posit_encoder.sv | 103 ++++++++++
 tb/tb_posit_encoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit widths, log2 helper and special-value constants
package posit_pkg;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int N_DEF  = 8;
  localparam int ES_DEF = 3;
  localparam int RS_DEF = log2(N_DEF);

  // Special encodings, returned wide and cast down to N bits by the user.
  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] posit_zero(input int n);
    return (n > 0) ? 64'd0 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction

endpackage

// File: rtl/posit_encoder_if.sv
// rtl/posit_encoder_if.sv - decoded-field input and posit output handshake bundle
interface posit_encoder_if #(
  parameter int N  = posit_pkg::N_DEF,
  parameter int ES = posit_pkg::ES_DEF,
  parameter int RS = posit_pkg::log2(N)
) ();
  logic                in_valid;
  logic                in_ready;
  logic                Sign;
  logic signed [RS:0]  RegimeValue;
  logic [ES-1:0]       Exponent;
  logic [N-1:0]        Mantissa;
  logic                Sticky;
  logic                IsZero;
  logic                IsNaR;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0]        out_posit;

  modport master (
    output in_valid, Sign, RegimeValue, Exponent, Mantissa, Sticky, IsZero, IsNaR, out_ready,
    input  in_ready, out_valid, out_posit
  );

  modport slave (
    input  in_valid, Sign, RegimeValue, Exponent, Mantissa, Sticky, IsZero, IsNaR, out_ready,
    output in_ready, out_valid, out_posit
  );
endinterface

// File: rtl/posit_round.sv
// rtl/posit_round.sv - round-to-nearest-even of a packed posit body, never to zero or NaR
module posit_round
  import posit_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-2:0] body,
  input  logic         guard,
  input  logic         sticky,
  input  logic         saturated,
  output logic [N-2:0] rounded
);

  always_comb begin
    rounded = body;
    // An all-ones body is maxpos; incrementing it would wrap into NaR.
    if (!saturated && guard && (body[0] || sticky) && !(&body))
      rounded = body + 1'b1;
    if (rounded == '0)
      rounded = (N-1)'(posit_minpos(N));
  end

endmodule

// File: rtl/posit_encoder.sv
// rtl/posit_encoder.sv - two-stage posit encoder: field pack, then round/negate
module posit_encoder
  import posit_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int ES = ES_DEF,
  parameter int RS = log2(N)
) (
  input  logic clk,
  input  logic reset,
  posit_encoder_if.slave bus
);

  // Longest regime run (N-1) plus terminator, exponent and mantissa fit in W.
  localparam int W = 2 * N + ES;
  localparam logic [N-1:0] NAR  = N'(posit_nar(N));
  localparam logic [N-1:0] ZERO = N'(posit_zero(N));

  logic               s1_valid, s2_valid, s1_adv;
  logic [N-2:0]       s1_body;
  logic               s1_guard, s1_sticky, s1_sat, s1_sign, s1_zero, s1_nar;
  logic [N-1:0]       s2_posit;

  logic signed [RS:0] k_field;
  int                 k, run;
  logic [W-1:0]       str;
  logic [N-2:0]       p_body;
  logic               p_guard, p_sticky, p_sat;

  logic [N-2:0]       rounded;
  logic [N-1:0]       pos, result;

  assign s1_adv        = !s2_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_posit = s2_posit;

  always_comb begin
    k_field = bus.RegimeValue;
    k       = int'(k_field);
    run     = (k >= 0) ? k + 1 : -k;
    str     = {(k < 0), bus.Exponent, bus.Mantissa, {(N-1){1'b0}}} >> run;
    if (k >= 0)
      str = str | ~({W{1'b1}} >> run);
    p_body   = str[W-1 -: N-1];
    p_guard  = str[W-N];
    p_sticky = (|str[W-N-1:0]) || bus.Sticky;
    p_sat    = 1'b0;
    if (k > N - 2) begin
      p_body = (N-1)'(posit_maxpos(N));
      p_sat  = 1'b1;
    end else if (k < -(N - 2)) begin
      p_body = (N-1)'(posit_minpos(N));
      p_sat  = 1'b1;
    end
    if (p_sat) begin
      p_guard  = 1'b0;
      p_sticky = 1'b0;
    end
  end

  posit_round #(.N(N)) u_round (
    .body      (s1_body),
    .guard     (s1_guard),
    .sticky    (s1_sticky),
    .saturated (s1_sat),
    .rounded   (rounded)
  );

  always_comb begin
    pos = {1'b0, rounded};
    if (s1_nar)       result = NAR;
    else if (s1_zero) result = ZERO;
    else if (s1_sign) result = ~pos + 1'b1;
    else              result = pos;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_posit <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_posit <= result;
      end
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_body   <= p_body;
          s1_guard  <= p_guard;
          s1_sticky <= p_sticky;
          s1_sat    <= p_sat;
          s1_sign   <= bus.Sign;
          s1_zero   <= bus.IsZero;
          s1_nar    <= bus.IsNaR;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// tb/tb_posit_encoder.sv - directed and randomized checks of posit_encoder against a bit-string model
module tb_posit_encoder;

  typedef struct {
    logic       sign;
    int         k;
    logic [2:0] e;
    logic [7:0] m;
    logic       st;
    logic       z;
    logic       nar;
  } fld_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  logic [7:0] sb[$];
  logic       hold_pending = 1'b0;
  logic [7:0] held;

  posit_encoder_if #(.N(8), .ES(3), .RS(3)) bus ();

  posit_encoder #(.N(8), .ES(3), .RS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic fld_t mk(input logic s, input int k, input logic [2:0] e,
                              input logic [7:0] m, input logic st, input logic z, input logic nar);
    fld_t f;
    f.sign = s; f.k = k; f.e = e; f.m = m; f.st = st; f.z = z; f.nar = nar;
    return f;
  endfunction

  function automatic fld_t rand_fld();
    fld_t f;
    f.sign = 1'($urandom_range(0, 1));
    f.k    = int'($urandom_range(0, 15)) - 8;
    f.e    = 3'($urandom_range(0, 7));
    f.m    = 8'($urandom_range(0, 255));
    f.st   = 1'($urandom_range(0, 1));
    f.z    = ($urandom_range(0, 15) == 0);
    f.nar  = ($urandom_range(0, 15) == 0);
    return f;
  endfunction

  // Reference: spell out the posit bit string, cut it, round on integers, negate mod 256.
  function automatic logic [7:0] ref_posit(input fld_t f);
    bit q[$];
    int body, val;
    bit guard, st;
    if (f.nar) return 8'h80;
    if (f.z) return 8'h00;
    if (f.k > 6) body = 127;
    else if (f.k < -6) body = 1;
    else begin
      if (f.k >= 0) begin
        repeat (f.k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-f.k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(f.e[i]);
      for (int i = 7; i >= 0; i--) q.push_back(f.m[i]);
      body = 0;
      for (int i = 0; i < 7; i++) body = body * 2 + int'(q[i]);
      guard = q[7];
      st = f.st;
      for (int i = 8; i < q.size(); i++) st = st | q[i];
      if (guard && ((body % 2) == 1 || st) && body != 127) body = body + 1;
      if (body == 0) body = 1;
    end
    val = f.sign ? (256 - body) % 256 : body;
    return val[7:0];
  endfunction

  task automatic drive(input logic v, input fld_t f, input logic ordy);
    bus.in_valid    = v;
    bus.Sign        = f.sign;
    bus.RegimeValue = f.k[3:0];
    bus.Exponent    = f.e;
    bus.Mantissa    = f.m;
    bus.Sticky      = f.st;
    bus.IsZero      = f.z;
    bus.IsNaR       = f.nar;
    bus.out_ready   = ordy;
  endtask

  // One clock cycle of streaming with scoreboard and stall-stability checks.
  task automatic step(input logic v, input fld_t f, input logic ordy, output logic in_fire);
    logic out_fire;
    @(negedge clk);
    drive(v, f, ordy);
    #1;
    in_fire  = bus.in_valid & bus.in_ready;
    out_fire = bus.out_valid & bus.out_ready;
    if (hold_pending) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_posit, held);
    end
    hold_pending = bus.out_valid & !bus.out_ready;
    held = bus.out_posit;
    if (out_fire) begin
      n_out++;
      if (sb.size() == 0) check("spurious_out", 1, 0);
      else check("stream_data", bus.out_posit, sb.pop_front());
    end
    if (in_fire) sb.push_back(ref_posit(f));
    @(posedge clk);
  endtask

  task automatic direct(input string tag, input fld_t f, input logic [7:0] exp);
    @(negedge clk);
    drive(1'b1, f, 1'b1);
    #1 check({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check({tag, "_early"}, bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, bus.out_valid, 1);
    check(tag, bus.out_posit, exp);
    @(posedge clk);
  endtask

  initial begin
    fld_t w[4];
    fld_t idle;
    logic fire;
    int idx, base, guard_cnt;

    idle = mk(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(1'b0, idle, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_posit", bus.out_posit, 0);

    direct("k1_e2",      mk(0,  1, 3'b010, 8'h00, 0, 0, 0), 8'h64);
    direct("km1_e7",     mk(0, -1, 3'b111, 8'h00, 0, 0, 0), 8'h3C);
    direct("km1_e7_neg", mk(1, -1, 3'b111, 8'h00, 0, 0, 0), 8'hC4);
    direct("round_up",   mk(0,  0, 3'b000, 8'h60, 0, 0, 0), 8'h42);
    direct("tie_even",   mk(0,  0, 3'b000, 8'h20, 0, 0, 0), 8'h40);
    direct("tie_sticky", mk(0,  0, 3'b000, 8'h20, 1, 0, 0), 8'h41);
    direct("sat_max",    mk(0,  7, 3'b101, 8'hFF, 1, 0, 0), 8'h7F);
    direct("sat_min",    mk(0, -8, 3'b101, 8'hFF, 1, 0, 0), 8'h01);
    direct("is_zero",    mk(1,  3, 3'b011, 8'h5A, 0, 1, 0), 8'h00);
    direct("nar_neg",    mk(1,  3, 3'b011, 8'h5A, 0, 1, 1), 8'h80);

    // Backpressure: out_ready low for 3 cycles while 4 words queue up.
    for (int i = 0; i < 4; i++) w[i] = rand_fld();
    idx = 0;
    base = n_out;
    for (int c = 0; c < 3; c++) begin
      step(idx < 4, (idx < 4) ? w[idx] : idle, 1'b0, fire);
      if (fire) idx++;
    end
    check("bp_accepted", idx, 2);
    #1 check("bp_in_ready", bus.in_ready, 0);
    guard_cnt = 0;
    while ((idx < 4 || sb.size() != 0) && guard_cnt < 20) begin
      step(idx < 4, (idx < 4) ? w[idx] : idle, 1'b1, fire);
      if (fire) idx++;
      guard_cnt++;
    end
    check("bp_emitted", n_out - base, 4);
    check("bp_drained", sb.size(), 0);

    // Reset with two words in flight.
    step(1'b1, rand_fld(), 1'b1, fire);
    step(1'b1, rand_fld(), 1'b1, fire);
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    sb.delete();
    hold_pending = 1'b0;
    base = n_out;
    repeat (5) step(1'b0, idle, 1'b1, fire);
    check("mid_rst_no_stale", n_out - base, 0);

    // Random traffic with random backpressure.
    repeat (400) step($urandom_range(0, 3) != 0, rand_fld(), $urandom_range(0, 3) != 0, fire);
    guard_cnt = 0;
    while (sb.size() != 0 && guard_cnt < 20) begin
      step(1'b0, idle, 1'b1, fire);
      guard_cnt++;
    end
    check("rand_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
